// File: rtl/exe_stage.sv
// EXE stage of the LA32R 5-stage pipeline.
// Latches the ID bundle on the ID->EXE handshake, computes the 12-op ALU
// result, issues the data SRAM request in the hand-off cycle to MEM and
// returns forwarding / load-use stall information to ID.
// Optional build macro EXE_PERF_CNT_EN adds three 32-bit event counters.
module exe_stage #(
  parameter logic [31:0] RESET_PC = 32'h1bfffffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_to_es_valid,
  input  logic [31:0] ds_pc,
  input  logic [31:0] ds_alu_src1,
  input  logic [31:0] ds_alu_src2,
  input  logic [11:0] ds_alu_op,
  input  logic        ds_sram_en,
  input  logic [3:0]  ds_sram_we,
  input  logic [31:0] ds_sram_wdata,
  input  logic [3:0]  ds_rf_we,
  input  logic [4:0]  ds_rf_waddr,
  input  logic [4:0]  ds_rf_raddr1,
  input  logic [4:0]  ds_rf_raddr2,
  input  logic        ms_allow_in,
  output logic        es_allow_in,
  output logic        es_to_ms_valid,
  output logic [31:0] es_pc,
  output logic        es_res_from_mem,
  output logic [3:0]  es_rf_we,
  output logic [4:0]  es_rf_waddr,
  output logic [31:0] es_rf_wdata,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  output logic        ld_use_stall
`ifdef EXE_PERF_CNT_EN
  ,
  output logic [31:0] es_inst_cnt,
  output logic [31:0] es_bp_cnt,
  output logic [31:0] es_lu_cnt
`endif
);

  logic        es_valid;
  logic        es_ready_go;
  logic [31:0] es_alu_src1;
  logic [31:0] es_alu_src2;
  logic [11:0] es_alu_op;
  logic [3:0]  es_sram_we;
  logic [3:0]  es_rf_we_reg;
  logic [31:0] alu_result;
  logic        handoff;

  assign es_ready_go    = 1'b1;
  assign es_allow_in    = !es_valid || (es_ready_go && ms_allow_in);
  assign es_to_ms_valid = es_valid && es_ready_go;
  assign handoff        = es_valid && ms_allow_in;

  // Stage valid: follows ID whenever EXE can accept, holds otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid <= 1'b0;
    end else if (es_allow_in) begin
      es_valid <= ds_to_es_valid;
    end
  end

  // Bundle latch: loads only on an accepted transfer, stable under backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      es_pc           <= RESET_PC;
      es_alu_src1     <= '0;
      es_alu_src2     <= '0;
      es_alu_op       <= '0;
      es_res_from_mem <= 1'b0;
      es_sram_we      <= '0;
      data_sram_wdata <= '0;
      es_rf_we_reg    <= '0;
      es_rf_waddr     <= '0;
    end else if (ds_to_es_valid && es_allow_in) begin
      es_pc           <= ds_pc;
      es_alu_src1     <= ds_alu_src1;
      es_alu_src2     <= ds_alu_src2;
      es_alu_op       <= ds_alu_op;
      es_res_from_mem <= ds_sram_en;
      es_sram_we      <= ds_sram_we;
      data_sram_wdata <= ds_sram_wdata;
      es_rf_we_reg    <= ds_rf_we;
      es_rf_waddr     <= ds_rf_waddr;
    end
  end

  // ALU: priority chain so the lowest set op bit wins on a non-one-hot vector
  always_comb begin
    alu_result = '0;
    if (es_alu_op[0])       alu_result = es_alu_src1 + es_alu_src2;
    else if (es_alu_op[1])  alu_result = es_alu_src1 - es_alu_src2;
    else if (es_alu_op[2])  alu_result = {31'b0, $signed(es_alu_src1) < $signed(es_alu_src2)};
    else if (es_alu_op[3])  alu_result = {31'b0, es_alu_src1 < es_alu_src2};
    else if (es_alu_op[4])  alu_result = es_alu_src1 & es_alu_src2;
    else if (es_alu_op[5])  alu_result = ~(es_alu_src1 | es_alu_src2);
    else if (es_alu_op[6])  alu_result = es_alu_src1 | es_alu_src2;
    else if (es_alu_op[7])  alu_result = es_alu_src1 ^ es_alu_src2;
    else if (es_alu_op[8])  alu_result = es_alu_src1 << es_alu_src2[4:0];
    else if (es_alu_op[9])  alu_result = es_alu_src1 >> es_alu_src2[4:0];
    else if (es_alu_op[10]) alu_result = $signed(es_alu_src1) >>> es_alu_src2[4:0];
    else if (es_alu_op[11]) alu_result = es_alu_src2;
  end

  // Forwarding: loads are never forwarded since their data is not ready yet
  assign es_rf_we    = es_rf_we_reg & {4{es_valid && !es_res_from_mem}};
  assign es_rf_wdata = alu_result;

  // Load-use hazard against either source of the instruction in ID
  assign ld_use_stall = es_valid && es_res_from_mem && (|es_rf_we_reg) &&
                        (es_rf_waddr != 5'd0) &&
                        ((es_rf_waddr == ds_rf_raddr1) || (es_rf_waddr == ds_rf_raddr2));

  // SRAM request only in the hand-off cycle so it is issued exactly once
  assign data_sram_en   = handoff && (es_res_from_mem || (|es_sram_we));
  assign data_sram_we   = es_sram_we & {4{handoff}};
  assign data_sram_addr = alu_result;

`ifdef EXE_PERF_CNT_EN
  // Event counters: hand-offs, backpressure cycles, load-use stall cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      es_inst_cnt <= '0;
      es_bp_cnt   <= '0;
      es_lu_cnt   <= '0;
    end else begin
      if (es_to_ms_valid && ms_allow_in) es_inst_cnt <= es_inst_cnt + 32'd1;
      if (es_valid && !ms_allow_in)      es_bp_cnt   <= es_bp_cnt + 32'd1;
      if (ld_use_stall)                  es_lu_cnt   <= es_lu_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed test-plan steps followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_exe_stage;

  localparam logic [31:0] RPC = 32'h1bfffffc;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_to_es_valid;
  logic [31:0] ds_pc, ds_alu_src1, ds_alu_src2, ds_sram_wdata;
  logic [11:0] ds_alu_op;
  logic        ds_sram_en;
  logic [3:0]  ds_sram_we, ds_rf_we;
  logic [4:0]  ds_rf_waddr, ds_rf_raddr1, ds_rf_raddr2;
  logic        ms_allow_in;
  logic        es_allow_in, es_to_ms_valid, es_res_from_mem;
  logic [31:0] es_pc, es_rf_wdata, data_sram_addr, data_sram_wdata;
  logic [3:0]  es_rf_we, data_sram_we;
  logic [4:0]  es_rf_waddr;
  logic        data_sram_en, ld_use_stall;
`ifdef EXE_PERF_CNT_EN
  logic [31:0] es_inst_cnt, es_bp_cnt, es_lu_cnt;
`endif

  always #5 clk = ~clk;

  exe_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .ds_to_es_valid(ds_to_es_valid), .ds_pc(ds_pc),
    .ds_alu_src1(ds_alu_src1), .ds_alu_src2(ds_alu_src2), .ds_alu_op(ds_alu_op),
    .ds_sram_en(ds_sram_en), .ds_sram_we(ds_sram_we), .ds_sram_wdata(ds_sram_wdata),
    .ds_rf_we(ds_rf_we), .ds_rf_waddr(ds_rf_waddr), .ds_rf_raddr1(ds_rf_raddr1),
    .ds_rf_raddr2(ds_rf_raddr2), .ms_allow_in(ms_allow_in), .es_allow_in(es_allow_in),
    .es_to_ms_valid(es_to_ms_valid), .es_pc(es_pc), .es_res_from_mem(es_res_from_mem),
    .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr), .es_rf_wdata(es_rf_wdata),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .ld_use_stall(ld_use_stall)
`ifdef EXE_PERF_CNT_EN
    , .es_inst_cnt(es_inst_cnt), .es_bp_cnt(es_bp_cnt), .es_lu_cnt(es_lu_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Model: one optional instruction held in EXE
  bit          m_valid;
  logic [31:0] m_pc, m_s1, m_s2, m_wd;
  logic [11:0] m_op;
  bit          m_ld;
  logic [3:0]  m_we, m_rfwe;
  logic [4:0]  m_wa;
  logic [31:0] m_inst, m_bp, m_lu;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [11:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int k;
    logic signed [31:0] sa;
    k = -1;
    sa = a;
    for (int i = 11; i >= 0; i--) if (op[i]) k = i;
    case (k)
      0:  return a + b;
      1:  return a - b;
      2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return a << b[4:0];
      9:  return a >> b[4:0];
      10: return sa >>> b[4:0];
      11: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit exp_stall();
    return m_valid && m_ld && (m_rfwe != 4'd0) && (m_wa != 5'd0) &&
           (m_wa == ds_rf_raddr1 || m_wa == ds_rf_raddr2);
  endfunction

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [11:0] op, input bit ld,
                       input logic [3:0] we, input logic [31:0] wd,
                       input logic [3:0] rfwe, input logic [4:0] wa);
    ds_to_es_valid = v;   ds_pc = pc;       ds_alu_src1 = s1; ds_alu_src2 = s2;
    ds_alu_op = op;       ds_sram_en = ld;  ds_sram_we = we;  ds_sram_wdata = wd;
    ds_rf_we = rfwe;      ds_rf_waddr = wa;
  endtask

  // Wait to the negative edge and compare every output with the model
  task automatic step();
    logic [31:0] res;
    bit hand;
    @(negedge clk);
    res  = ref_alu(m_op, m_s1, m_s2);
    hand = m_valid && ms_allow_in;
    chk("allow_in",   {31'b0, es_allow_in},     {31'b0, !m_valid || ms_allow_in});
    chk("to_ms",      {31'b0, es_to_ms_valid},  {31'b0, m_valid});
    chk("pc",         es_pc,                    m_pc);
    chk("res_mem",    {31'b0, es_res_from_mem}, {31'b0, m_ld});
    chk("rf_we",      {28'b0, es_rf_we},        {28'b0, (m_valid && !m_ld) ? m_rfwe : 4'd0});
    chk("rf_waddr",   {27'b0, es_rf_waddr},     {27'b0, m_wa});
    chk("rf_wdata",   es_rf_wdata,              res);
    chk("sram_en",    {31'b0, data_sram_en},    {31'b0, hand && (m_ld || m_we != 4'd0)});
    chk("sram_we",    {28'b0, data_sram_we},    {28'b0, hand ? m_we : 4'd0});
    chk("sram_addr",  data_sram_addr,           res);
    chk("sram_wdata", data_sram_wdata,          m_wd);
    chk("stall",      {31'b0, ld_use_stall},    {31'b0, exp_stall()});
`ifdef EXE_PERF_CNT_EN
    chk("inst_cnt",   es_inst_cnt,              m_inst);
    chk("bp_cnt",     es_bp_cnt,                m_bp);
    chk("lu_cnt",     es_lu_cnt,                m_lu);
`endif
  endtask

  // Apply the current inputs to the model across the next rising edge
  task automatic adv();
    bit allow, stall;
    allow = !m_valid || ms_allow_in;
    stall = exp_stall();
    if (reset) begin
      m_valid = 0; m_pc = RPC; m_s1 = '0; m_s2 = '0; m_op = '0; m_ld = 0;
      m_we = '0; m_wd = '0; m_rfwe = '0; m_wa = '0;
      m_inst = '0; m_bp = '0; m_lu = '0;
    end else begin
      if (m_valid && ms_allow_in)  m_inst = m_inst + 32'd1;
      if (m_valid && !ms_allow_in) m_bp   = m_bp + 32'd1;
      if (stall)                   m_lu   = m_lu + 32'd1;
      if (allow && ds_to_es_valid) begin
        m_pc = ds_pc; m_s1 = ds_alu_src1; m_s2 = ds_alu_src2; m_op = ds_alu_op;
        m_ld = ds_sram_en; m_we = ds_sram_we; m_wd = ds_sram_wdata;
        m_rfwe = ds_rf_we; m_wa = ds_rf_waddr;
      end
      if (allow) m_valid = ds_to_es_valid;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int ho;
    reset = 1; ms_allow_in = 1; ds_rf_raddr1 = 0; ds_rf_raddr2 = 0;
    drive(0, '0, '0, '0, '0, 0, '0, '0, '0, '0);
    adv();
    reset = 0;
    step();
    chk("rst_pc",    es_pc, RPC);
    chk("rst_allow", {31'b0, es_allow_in}, 32'd1);
    chk("rst_tomv",  {31'b0, es_to_ms_valid}, 32'd0);
    chk("rst_sram",  {31'b0, data_sram_en}, 32'd0);
    adv();

    // ALU corner cases, issued back to back
    drive(1, 32'h1c000000, 32'h7fffffff, 32'd1, 12'h001, 0, 4'h0, '0, 4'hf, 5'd3);
    step(); adv();
    drive(1, 32'h1c000004, 32'hffffffff, 32'd0, 12'h004, 0, 4'h0, '0, 4'hf, 5'd4);
    step();
    chk("add_ovf", es_rf_wdata, 32'h80000000);
    chk("add_tomv", {31'b0, es_to_ms_valid}, 32'd1);
    chk("add_rfwe", {28'b0, es_rf_we}, 32'hf);
    adv();
    drive(1, 32'h1c000008, 32'hffffffff, 32'd0, 12'h008, 0, 4'h0, '0, 4'hf, 5'd4);
    step(); chk("slt", es_rf_wdata, 32'd1); adv();
    drive(1, 32'h1c00000c, 32'h80000000, 32'd31, 12'h400, 0, 4'h0, '0, 4'hf, 5'd4);
    step(); chk("sltu", es_rf_wdata, 32'd0); adv();
    drive(1, 32'h1c000010, 32'h80000000, 32'd31, 12'h200, 0, 4'h0, '0, 4'hf, 5'd4);
    step(); chk("sra", es_rf_wdata, 32'hffffffff); adv();
    drive(1, 32'h1c000014, 32'h1c000000, 32'd4, 12'h001, 1, 4'h0, '0, 4'hf, 5'd5);
    step(); chk("srl", es_rf_wdata, 32'd1); adv();

    // Load to r5 held under backpressure
    ms_allow_in = 0; ds_rf_raddr1 = 5;
    drive(1, 32'h1c000018, 32'd1, 32'd2, 12'h001, 0, 4'h0, '0, 4'hf, 5'd6);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_stall",  {31'b0, ld_use_stall}, 32'd1);
      chk("bp_sram",   {31'b0, data_sram_en}, 32'd0);
      chk("bp_allow",  {31'b0, es_allow_in}, 32'd0);
      chk("bp_pc",     es_pc, 32'h1c000014);
      adv();
    end
    ds_rf_raddr1 = 0;
    step(); chk("nostall", {31'b0, ld_use_stall}, 32'd0); adv();
    ms_allow_in = 1;
    step(); chk("ld_req", {31'b0, data_sram_en}, 32'd1); adv();
    ds_to_es_valid = 0;
    step(); chk("ld_req_once", {31'b0, data_sram_en}, 32'd0);
    chk("refill_waddr", {27'b0, es_rf_waddr}, 32'd6); adv();

    // Store
    drive(1, 32'h1c00001c, 32'h1c000000, 32'd8, 12'h001, 0, 4'hf, 32'hdeadbeef, 4'h0, 5'd0);
    step(); adv();
    ds_to_es_valid = 0;
    step();
    chk("st_addr",  data_sram_addr, 32'h1c000008);
    chk("st_we",    {28'b0, data_sram_we}, 32'hf);
    chk("st_wdata", data_sram_wdata, 32'hdeadbeef);
    adv();

    // Back-to-back stream, reset mid-stream
    ho = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h1c000100 + 32'(i * 4), 32'(i), 32'd16, 12'h001, 0, 4'h0, '0, 4'hf, 5'(i + 8));
      if (i == 4) reset = 1;
      step();
      if (i > 0 && es_to_ms_valid && ms_allow_in) ho++;
      adv();
    end
    reset = 0; ds_to_es_valid = 0;
    step();
    chk("b2b_handoffs", 32'(ho), 32'd4);
    chk("mid_rst_valid", {31'b0, es_to_ms_valid}, 32'd0);
    chk("mid_rst_sram",  {31'b0, data_sram_en}, 32'd0);
    chk("mid_rst_allow", {31'b0, es_allow_in}, 32'd1);
`ifdef EXE_PERF_CNT_EN
    chk("inst_cnt_clr", es_inst_cnt, 32'd0);
`endif
    adv();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [11:0] op;
      bit ld;
      reset = ($urandom_range(0, 49) == 0);
      ms_allow_in = ($urandom_range(0, 3) != 0);
      op = ($urandom_range(0, 9) == 0) ? 12'($urandom) : (12'h001 << $urandom_range(0, 11));
      ld = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom,
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom, op, ld,
            (!ld && $urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0, $urandom,
            ($urandom_range(0, 3) == 0) ? 4'h0 : 4'hf, 5'($urandom_range(0, 7)));
      ds_rf_raddr1 = 5'($urandom_range(0, 7));
      ds_rf_raddr2 = 5'($urandom_range(0, 7));
      step();
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
